// File: rtl/reg_alloc_unit.sv
// rtl/reg_alloc_unit.sv - per-warp register-pair allocator with combinational lookup
//
// Purpose: hands each newly launched hardware warp a private set of physical
// register pairs out of a shared pool, one pair per cycle. It returns the pairs
// to the pool when the warp exits. It also translates (warp, architectural
// register) into a physical register address for the register-file stage.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   Update_TM_RAU            allocation request pulse
//   Nreg_TM_RAU              pairs requested (0..MAX_PAIRS legal)
//   HWWarpID_TM_RAU          hardware warp being launched
//   SWWarpID_TM_RAU          software warp ID stored for that warp
//   Alloc_BusyBar_RAU_TM     1 = idle, can accept an Update (registered)
//   Exit_IB_RAU_TM           warp exit pulse
//   WarpID_IU_TM             exiting warp
//   WarpID_RF_RAU            lookup warp
//   ArchReg_RF_RAU           lookup architectural register
//   PhyReg_RAU_RF            physical register address (combinational)
//   Valid_RAU_RF             lookup hit (combinational)
//   SWWarpID_RAU_RF          stored software ID of the lookup warp (combinational)
//   FreePairs_RAU            number of unowned pairs (registered)
//   Err_RAU                  sticky protocol error, cleared only by reset
//
// Port widths are sized for the default parameter set (8 warps, 16 pairs, 4 per warp).

module reg_alloc_unit #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_PAIRS = 16,
  parameter int MAX_PAIRS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Update_TM_RAU,
  input  logic [2:0] Nreg_TM_RAU,
  input  logic [2:0] HWWarpID_TM_RAU,
  input  logic [7:0] SWWarpID_TM_RAU,
  output logic       Alloc_BusyBar_RAU_TM,
  input  logic       Exit_IB_RAU_TM,
  input  logic [2:0] WarpID_IU_TM,
  input  logic [2:0] WarpID_RF_RAU,
  input  logic [2:0] ArchReg_RF_RAU,
  output logic [4:0] PhyReg_RAU_RF,
  output logic       Valid_RAU_RF,
  output logic [7:0] SWWarpID_RAU_RF,
  output logic [4:0] FreePairs_RAU,
  output logic       Err_RAU
);

  typedef enum logic {S_IDLE = 1'b0, S_ALLOC = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_PAIRS-1:0]   r_bitmap;
  logic [NUM_WARPS-1:0]   r_valid;
  logic [2:0]             r_npairs [NUM_WARPS];
  logic [3:0]             r_slot   [NUM_WARPS][MAX_PAIRS];
  logic [7:0]             r_swid   [NUM_WARPS];
  logic [2:0]             r_aw;     // warp currently being allocated
  logic [2:0]             r_an;     // pairs it asked for
  logic [2:0]             r_k;      // pairs granted so far
  logic [4:0]             r_free;
  logic                   r_err;

  logic                   w_idle;
  logic                   w_upd_ok;
  logic                   w_upd_bad;
  logic                   w_exit_ok;
  logic                   w_exit_bad;
  logic                   w_found;
  logic [3:0]             w_idx;
  logic                   w_grant;
  logic                   w_last;
  logic                   w_fail;
  logic [NUM_PAIRS-1:0]   w_freemask;
  logic [NUM_PAIRS-1:0]   w_allocmask;
  logic [NUM_PAIRS-1:0]   w_bitmap_nxt;
  logic [4:0]             w_used;
  logic [1:0]             w_lp;
  logic                   w_lv;

  assign w_idle     = (r_state == S_IDLE);
  assign w_upd_ok   = Update_TM_RAU && w_idle && (Nreg_TM_RAU <= 3'(MAX_PAIRS))
                      && !r_valid[HWWarpID_TM_RAU];
  assign w_upd_bad  = Update_TM_RAU && !w_upd_ok;
  // The warp mid-allocation cannot exit: its slot list is still being built.
  assign w_exit_ok  = Exit_IB_RAU_TM && r_valid[WarpID_IU_TM]
                      && !(!w_idle && (WarpID_IU_TM == r_aw));
  assign w_exit_bad = Exit_IB_RAU_TM && !w_exit_ok;

  // Lowest free pair. Scanning downward lets the last hit (lowest index) win.
  // It looks at the pre-exit bitmap, so pairs freed this cycle are reused next cycle.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NUM_PAIRS - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) begin
        w_found = 1'b1;
        w_idx   = 4'(i);
      end
    end
  end

  assign w_grant = !w_idle && w_found;
  assign w_last  = w_grant && ((r_k + 3'd1) == r_an);
  assign w_fail  = !w_idle && !w_found;

  always_comb begin
    w_freemask = '0;
    if (w_exit_ok) begin
      for (int s = 0; s < MAX_PAIRS; s++) begin
        if (3'(s) < r_npairs[WarpID_IU_TM]) begin
          w_freemask[r_slot[WarpID_IU_TM][s]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_allocmask = '0;
    if (w_grant) begin
      w_allocmask[w_idx] = 1'b1;
    end
  end

  assign w_bitmap_nxt = (r_bitmap & ~w_freemask) | w_allocmask;

  always_comb begin
    w_used = '0;
    for (int i = 0; i < NUM_PAIRS; i++) begin
      w_used = w_used + 5'(w_bitmap_nxt[i]);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_upd_ok && (Nreg_TM_RAU != 3'd0)) begin
          w_state_nxt = S_ALLOC;
        end
      end
      S_ALLOC: begin
        if (w_last || w_fail) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Alloc_BusyBar_RAU_TM = (r_state == S_IDLE);
  end

  // Datapath: pool bitmap, per-warp tables, allocation progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitmap <= '0;
      r_valid  <= '0;
      r_aw     <= '0;
      r_an     <= '0;
      r_k      <= '0;
      r_free   <= 5'(NUM_PAIRS);
      r_err    <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_npairs[w] <= '0;
        r_swid[w]   <= '0;
        for (int s = 0; s < MAX_PAIRS; s++) begin
          r_slot[w][s] <= '0;
        end
      end
    end else begin
      r_bitmap <= w_bitmap_nxt;
      r_free   <= 5'(NUM_PAIRS) - w_used;
      if (w_upd_bad || w_exit_bad || w_fail) begin
        r_err <= 1'b1;
      end
      if (w_exit_ok) begin
        r_valid[WarpID_IU_TM] <= 1'b0;
      end
      if (w_upd_ok) begin
        r_valid[HWWarpID_TM_RAU]  <= 1'b1;
        r_npairs[HWWarpID_TM_RAU] <= Nreg_TM_RAU;
        r_swid[HWWarpID_TM_RAU]   <= SWWarpID_TM_RAU;
        r_aw                      <= HWWarpID_TM_RAU;
        r_an                      <= Nreg_TM_RAU;
        r_k                       <= '0;
      end
      if (w_grant) begin
        r_slot[r_aw][r_k[1:0]] <= w_idx;
        r_k                    <= r_k + 3'd1;
      end
      // Pool exhausted: the warp keeps what it already got.
      if (w_fail) begin
        r_npairs[r_aw] <= r_k;
      end
    end
  end

  // Lookup: each pair holds an even/odd register couple selected by ArchReg[0].
  assign w_lp = ArchReg_RF_RAU[2:1];
  assign w_lv = r_valid[WarpID_RF_RAU]
                && ({1'b0, w_lp} < r_npairs[WarpID_RF_RAU])
                && (w_idle || (WarpID_RF_RAU != r_aw) || ({1'b0, w_lp} < r_k));

  assign Valid_RAU_RF    = w_lv;
  assign PhyReg_RAU_RF   = w_lv ? {r_slot[WarpID_RF_RAU][w_lp], ArchReg_RF_RAU[0]} : 5'd0;
  assign SWWarpID_RAU_RF = r_swid[WarpID_RF_RAU];
  assign FreePairs_RAU   = r_free;
  assign Err_RAU         = r_err;

endmodule

// File: tb/tb_reg_alloc_unit.sv
// tb/tb_reg_alloc_unit.sv - randomized and directed bench for reg_alloc_unit
`timescale 1ns/1ps

module tb_reg_alloc_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Update_TM_RAU = 1'b0;
  logic [2:0] Nreg_TM_RAU = '0;
  logic [2:0] HWWarpID_TM_RAU = '0;
  logic [7:0] SWWarpID_TM_RAU = '0;
  logic       Alloc_BusyBar_RAU_TM;
  logic       Exit_IB_RAU_TM = 1'b0;
  logic [2:0] WarpID_IU_TM = '0;
  logic [2:0] WarpID_RF_RAU = '0;
  logic [2:0] ArchReg_RF_RAU = '0;
  logic [4:0] PhyReg_RAU_RF;
  logic       Valid_RAU_RF;
  logic [7:0] SWWarpID_RAU_RF;
  logic [4:0] FreePairs_RAU;
  logic       Err_RAU;

  int total = 0;
  int bad = 0;

  reg_alloc_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .Update_TM_RAU        (Update_TM_RAU),
    .Nreg_TM_RAU          (Nreg_TM_RAU),
    .HWWarpID_TM_RAU      (HWWarpID_TM_RAU),
    .SWWarpID_TM_RAU      (SWWarpID_TM_RAU),
    .Alloc_BusyBar_RAU_TM (Alloc_BusyBar_RAU_TM),
    .Exit_IB_RAU_TM       (Exit_IB_RAU_TM),
    .WarpID_IU_TM         (WarpID_IU_TM),
    .WarpID_RF_RAU        (WarpID_RF_RAU),
    .ArchReg_RF_RAU       (ArchReg_RF_RAU),
    .PhyReg_RAU_RF        (PhyReg_RAU_RF),
    .Valid_RAU_RF         (Valid_RAU_RF),
    .SWWarpID_RAU_RF      (SWWarpID_RAU_RF),
    .FreePairs_RAU        (FreePairs_RAU),
    .Err_RAU              (Err_RAU)
  );

  always #10 clk = ~clk;

  // Reference model: pool ownership flags and, per warp, the ordered list of granted pairs.
  bit       m_owned [16];
  int       m_slots [8][$];
  bit       m_valid [8];
  bit [7:0] m_sw    [8];
  bit       m_busy;
  bit       m_err;
  int       m_aw;
  int       m_nreq;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_owned[i] = 1'b0;
    for (int w = 0; w < 8; w++) begin
      m_slots[w].delete();
      m_valid[w] = 1'b0;
      m_sw[w] = 8'd0;
    end
    m_busy = 1'b0;
    m_err = 1'b0;
    m_aw = 0;
    m_nreq = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int  grant;
    bit  fail;
    bit  acc;
    int  freed[$];
    int  h;
    int  n;
    int  e;
    grant = -1;
    fail = 1'b0;
    acc = 1'b0;
    h = int'(HWWarpID_TM_RAU);
    n = int'(Nreg_TM_RAU);
    e = int'(WarpID_IU_TM);
    if (Update_TM_RAU) begin
      if (!m_busy && n <= 4 && !m_valid[h]) acc = 1'b1;
      else m_err = 1'b1;
    end
    if (m_busy) begin
      for (int i = 15; i >= 0; i--) if (!m_owned[i]) grant = i;
      if (grant < 0) fail = 1'b1;
    end
    if (Exit_IB_RAU_TM) begin
      if (m_valid[e] && !(m_busy && e == m_aw)) begin
        freed = m_slots[e];
        m_slots[e].delete();
        m_valid[e] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    foreach (freed[i]) m_owned[freed[i]] = 1'b0;
    if (grant >= 0) begin
      m_owned[grant] = 1'b1;
      m_slots[m_aw].push_back(grant);
      if (m_slots[m_aw].size() == m_nreq) m_busy = 1'b0;
    end
    if (fail) begin
      m_busy = 1'b0;
      m_err = 1'b1;
    end
    if (acc) begin
      m_valid[h] = 1'b1;
      m_sw[h] = SWWarpID_TM_RAU;
      m_slots[h].delete();
      m_nreq = n;
      m_aw = h;
      if (n > 0) m_busy = 1'b1;
    end
  endtask

  function automatic bit exp_valid(int w, int r);
    return m_valid[w] && ((r / 2) < m_slots[w].size());
  endfunction

  function automatic int exp_phy(int w, int r);
    if (!exp_valid(w, r)) return 0;
    return m_slots[w][r / 2] * 2 + (r % 2);
  endfunction

  function automatic int exp_free();
    int c;
    c = 16;
    for (int i = 0; i < 16; i++) if (m_owned[i]) c--;
    return c;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    Update_TM_RAU = 1'b0;
    Exit_IB_RAU_TM = 1'b0;
  endtask

  task automatic do_reset();
    Update_TM_RAU = 1'b0;
    Exit_IB_RAU_TM = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(int w, int n, int sw);
    Update_TM_RAU = 1'b1;
    HWWarpID_TM_RAU = 3'(w);
    Nreg_TM_RAU = 3'(n);
    SWWarpID_TM_RAU = 8'(sw);
  endtask

  task automatic ex(int w);
    Exit_IB_RAU_TM = 1'b1;
    WarpID_IU_TM = 3'(w);
  endtask

  task automatic look(int w, int r);
    WarpID_RF_RAU = 3'(w);
    ArchReg_RF_RAU = 3'(r);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (Alloc_BusyBar_RAU_TM !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    total++;
    if (Alloc_BusyBar_RAU_TM !== 1'b1) begin
      bad++;
      $display("FAIL %s_idle_timeout busy=%0b want=1", tag, Alloc_BusyBar_RAU_TM);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (Alloc_BusyBar_RAU_TM !== 1'b1) begin bad++; $display("FAIL reset_busy got=%0b want=1", Alloc_BusyBar_RAU_TM); end
    total++; if (FreePairs_RAU !== 5'd16) begin bad++; $display("FAIL reset_free got=%0d want=16", FreePairs_RAU); end
    total++; if (Err_RAU !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", Err_RAU); end
    look(0, 0);
    total++; if (Valid_RAU_RF !== 1'b0 || PhyReg_RAU_RF !== 5'd0) begin bad++; $display("FAIL reset_lookup valid=%0b phy=%0d want 0/0", Valid_RAU_RF, PhyReg_RAU_RF); end
    look(7, 7);
    total++; if (SWWarpID_RAU_RF !== 8'd0) begin bad++; $display("FAIL reset_swid got=%0h want=0", SWWarpID_RAU_RF); end
  endtask

  task automatic test_basic_alloc();
    int c;
    do_reset();
    upd(0, 3, 'hA5);
    tick();
    c = 0;
    while (Alloc_BusyBar_RAU_TM === 1'b0 && c < 10) begin
      c++;
      tick();
    end
    total++; if (c != 3) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=3", c); end
    total++; if (FreePairs_RAU !== 5'd13) begin bad++; $display("FAIL basic_free got=%0d want=13", FreePairs_RAU); end
    look(0, 5);
    total++; if (Valid_RAU_RF !== 1'b1 || PhyReg_RAU_RF !== 5'd5) begin bad++; $display("FAIL basic_w0r5 valid=%0b phy=%0d want 1/5", Valid_RAU_RF, PhyReg_RAU_RF); end
    look(0, 6);
    total++; if (Valid_RAU_RF !== 1'b0) begin bad++; $display("FAIL basic_w0r6 valid=%0b want=0", Valid_RAU_RF); end
    total++; if (SWWarpID_RAU_RF !== 8'hA5) begin bad++; $display("FAIL basic_swid got=%0h want=a5", SWWarpID_RAU_RF); end
    for (int r = 0; r < 8; r++) begin
      look(0, r);
      total++;
      if (Valid_RAU_RF !== exp_valid(0, r) || PhyReg_RAU_RF !== 5'(exp_phy(0, r))) begin
        bad++;
        $display("FAIL basic_lookup r=%0d valid=%0b phy=%0d want %0b/%0d", r, Valid_RAU_RF, PhyReg_RAU_RF, exp_valid(0, r), exp_phy(0, r));
      end
    end
    ex(0);
    tick();
    total++; if (FreePairs_RAU !== 5'd16) begin bad++; $display("FAIL basic_exit_free got=%0d want=16", FreePairs_RAU); end
  endtask

  task automatic test_fragmentation();
    do_reset();
    upd(0, 2, 1); tick(); wait_idle("frag0");
    upd(1, 2, 2); tick(); wait_idle("frag1");
    ex(0); tick();
    upd(2, 3, 3); tick(); wait_idle("frag2");
    look(2, 0);
    total++; if (PhyReg_RAU_RF !== 5'd0 || Valid_RAU_RF !== 1'b1) begin bad++; $display("FAIL frag_w2r0 phy=%0d valid=%0b want 0/1", PhyReg_RAU_RF, Valid_RAU_RF); end
    look(2, 3);
    total++; if (PhyReg_RAU_RF !== 5'd3) begin bad++; $display("FAIL frag_w2r3 phy=%0d want=3", PhyReg_RAU_RF); end
    look(2, 4);
    total++; if (PhyReg_RAU_RF !== 5'd8 || Valid_RAU_RF !== 1'b1) begin bad++; $display("FAIL frag_w2r4 phy=%0d valid=%0b want 8/1", PhyReg_RAU_RF, Valid_RAU_RF); end
    look(1, 1);
    total++; if (PhyReg_RAU_RF !== 5'd5) begin bad++; $display("FAIL frag_w1r1 phy=%0d want=5", PhyReg_RAU_RF); end
    total++; if (FreePairs_RAU !== 5'd11) begin bad++; $display("FAIL frag_free got=%0d want=11", FreePairs_RAU); end
  endtask

  task automatic test_nreg_zero();
    do_reset();
    upd(3, 0, 'h3C);
    tick();
    total++; if (Alloc_BusyBar_RAU_TM !== 1'b1) begin bad++; $display("FAIL nreg0_busy got=%0b want=1", Alloc_BusyBar_RAU_TM); end
    for (int r = 0; r < 8; r++) begin
      look(3, r);
      total++; if (Valid_RAU_RF !== 1'b0 || PhyReg_RAU_RF !== 5'd0) begin bad++; $display("FAIL nreg0_lookup r=%0d valid=%0b phy=%0d want 0/0", r, Valid_RAU_RF, PhyReg_RAU_RF); end
    end
    total++; if (SWWarpID_RAU_RF !== 8'h3C) begin bad++; $display("FAIL nreg0_swid got=%0h want=3c", SWWarpID_RAU_RF); end
    total++; if (FreePairs_RAU !== 5'd16 || Err_RAU !== 1'b0) begin bad++; $display("FAIL nreg0_state free=%0d err=%0b want 16/0", FreePairs_RAU, Err_RAU); end
  endtask

  task automatic test_overlap();
    do_reset();
    upd(1, 4, 'h11); tick(); wait_idle("ovl1");
    upd(2, 4, 'h22); tick();
    tick();
    look(2, 0);
    total++; if (Valid_RAU_RF !== 1'b1 || PhyReg_RAU_RF !== 5'd8) begin bad++; $display("FAIL ovl_first valid=%0b phy=%0d want 1/8", Valid_RAU_RF, PhyReg_RAU_RF); end
    look(2, 2);
    total++; if (Valid_RAU_RF !== 1'b0) begin bad++; $display("FAIL ovl_partial valid=%0b want=0", Valid_RAU_RF); end
    ex(1);
    tick();
    total++; if (FreePairs_RAU !== 5'd14) begin bad++; $display("FAIL ovl_exit_free got=%0d want=14", FreePairs_RAU); end
    wait_idle("ovl2");
    look(2, 2);
    total++; if (PhyReg_RAU_RF !== 5'd10) begin bad++; $display("FAIL ovl_r2 phy=%0d want=10", PhyReg_RAU_RF); end
    look(2, 4);
    total++; if (PhyReg_RAU_RF !== 5'd0 || Valid_RAU_RF !== 1'b1) begin bad++; $display("FAIL ovl_r4 phy=%0d valid=%0b want 0/1", PhyReg_RAU_RF, Valid_RAU_RF); end
    look(2, 7);
    total++; if (PhyReg_RAU_RF !== 5'd3) begin bad++; $display("FAIL ovl_r7 phy=%0d want=3", PhyReg_RAU_RF); end
    total++; if (FreePairs_RAU !== 5'd12 || Err_RAU !== 1'b0) begin bad++; $display("FAIL ovl_final free=%0d err=%0b want 12/0", FreePairs_RAU, Err_RAU); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd(0, 1, 'h10); tick();
    tick();
    total++; if (Alloc_BusyBar_RAU_TM !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b want=1", Alloc_BusyBar_RAU_TM); end
    upd(1, 2, 'h20); tick();
    total++; if (Alloc_BusyBar_RAU_TM !== 1'b0) begin bad++; $display("FAIL b2b_accept busy=%0b want=0", Alloc_BusyBar_RAU_TM); end
    wait_idle("b2b");
    look(1, 3);
    total++; if (PhyReg_RAU_RF !== 5'd5 || Valid_RAU_RF !== 1'b1) begin bad++; $display("FAIL b2b_w1r3 phy=%0d valid=%0b want 5/1", PhyReg_RAU_RF, Valid_RAU_RF); end
    total++; if (FreePairs_RAU !== 5'd13 || Err_RAU !== 1'b0) begin bad++; $display("FAIL b2b_state free=%0d err=%0b want 13/0", FreePairs_RAU, Err_RAU); end
  endtask

  task automatic test_errors();
    do_reset();
    upd(0, 2, 1); tick();
    upd(5, 1, 'h55); tick();
    wait_idle("err_busy");
    look(5, 0);
    total++; if (Err_RAU !== 1'b1 || Valid_RAU_RF !== 1'b0 || FreePairs_RAU !== 5'd14) begin bad++; $display("FAIL err_update_busy err=%0b valid=%0b free=%0d want 1/0/14", Err_RAU, Valid_RAU_RF, FreePairs_RAU); end
    do_reset();
    upd(4, 6, 'h44); tick();
    look(4, 0);
    total++; if (Err_RAU !== 1'b1 || Alloc_BusyBar_RAU_TM !== 1'b1 || Valid_RAU_RF !== 1'b0 || SWWarpID_RAU_RF !== 8'd0) begin bad++; $display("FAIL err_nreg6 err=%0b busy=%0b valid=%0b sw=%0h want 1/1/0/0", Err_RAU, Alloc_BusyBar_RAU_TM, Valid_RAU_RF, SWWarpID_RAU_RF); end
    do_reset();
    ex(6); tick();
    total++; if (Err_RAU !== 1'b1 || FreePairs_RAU !== 5'd16) begin bad++; $display("FAIL err_exit_invalid err=%0b free=%0d want 1/16", Err_RAU, FreePairs_RAU); end
    do_reset();
    upd(3, 2, 3); tick();
    ex(3); tick();
    wait_idle("err_exit_alloc");
    look(3, 2);
    total++; if (Err_RAU !== 1'b1 || Valid_RAU_RF !== 1'b1 || PhyReg_RAU_RF !== 5'd2 || FreePairs_RAU !== 5'd14) begin bad++; $display("FAIL err_exit_alloc err=%0b valid=%0b phy=%0d free=%0d want 1/1/2/14", Err_RAU, Valid_RAU_RF, PhyReg_RAU_RF, FreePairs_RAU); end
  endtask

  task automatic test_fill_and_reset();
    do_reset();
    for (int w = 0; w < 4; w++) begin
      upd(w, 4, w); tick(); wait_idle("fill");
    end
    total++; if (FreePairs_RAU !== 5'd0 || Err_RAU !== 1'b0) begin bad++; $display("FAIL fill_full free=%0d err=%0b want 0/0", FreePairs_RAU, Err_RAU); end
    ex(2); tick();
    upd(4, 4, 'h44); tick(); wait_idle("refill");
    look(4, 0);
    total++; if (PhyReg_RAU_RF !== 5'd16 || Valid_RAU_RF !== 1'b1) begin bad++; $display("FAIL refill_r0 phy=%0d valid=%0b want 16/1", PhyReg_RAU_RF, Valid_RAU_RF); end
    look(4, 7);
    total++; if (PhyReg_RAU_RF !== 5'd23) begin bad++; $display("FAIL refill_r7 phy=%0d want=23", PhyReg_RAU_RF); end
    total++; if (FreePairs_RAU !== 5'd0 || Err_RAU !== 1'b0) begin bad++; $display("FAIL refill_state free=%0d err=%0b want 0/0", FreePairs_RAU, Err_RAU); end
    upd(6, 1, 'h66); tick();
    tick();
    look(6, 0);
    total++; if (Err_RAU !== 1'b1 || Alloc_BusyBar_RAU_TM !== 1'b1 || Valid_RAU_RF !== 1'b0) begin bad++; $display("FAIL exhaust err=%0b busy=%0b valid=%0b want 1/1/0", Err_RAU, Alloc_BusyBar_RAU_TM, Valid_RAU_RF); end
    ex(0); tick();
    upd(5, 4, 'h55); tick();
    tick();
    total++; if (Alloc_BusyBar_RAU_TM !== 1'b0) begin bad++; $display("FAIL midalloc_busy got=%0b want=0", Alloc_BusyBar_RAU_TM); end
    rst = 1'b0;
    #2;
    look(5, 0);
    total++; if (Alloc_BusyBar_RAU_TM !== 1'b1 || FreePairs_RAU !== 5'd16 || Err_RAU !== 1'b0) begin bad++; $display("FAIL async_reset busy=%0b free=%0d err=%0b want 1/16/0", Alloc_BusyBar_RAU_TM, FreePairs_RAU, Err_RAU); end
    total++; if (Valid_RAU_RF !== 1'b0 || PhyReg_RAU_RF !== 5'd0 || SWWarpID_RAU_RF !== 8'd0) begin bad++; $display("FAIL async_reset_lookup valid=%0b phy=%0d sw=%0h want 0/0/0", Valid_RAU_RF, PhyReg_RAU_RF, SWWarpID_RAU_RF); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int cands[$];
    int lw;
    int lr;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 75 == 74) do_reset();
      if (Alloc_BusyBar_RAU_TM === 1'b1) Update_TM_RAU = ($urandom % 2 == 0);
      else Update_TM_RAU = ($urandom % 16 == 0);
      HWWarpID_TM_RAU = 3'($urandom % 8);
      Nreg_TM_RAU = ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
      SWWarpID_TM_RAU = 8'($urandom);
      Exit_IB_RAU_TM = ($urandom % 4 == 0);
      cands.delete();
      for (int w = 0; w < 8; w++) if (m_valid[w]) cands.push_back(w);
      if (cands.size() > 0 && $urandom % 4 != 0) WarpID_IU_TM = 3'(cands[$urandom % cands.size()]);
      else WarpID_IU_TM = 3'($urandom % 8);
      tick();
      total++; if (Alloc_BusyBar_RAU_TM !== !m_busy) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0b want=%0b", cyc, Alloc_BusyBar_RAU_TM, !m_busy); end
      total++; if (FreePairs_RAU !== 5'(exp_free())) begin bad++; $display("FAIL rnd_free cyc=%0d got=%0d want=%0d", cyc, FreePairs_RAU, exp_free()); end
      total++; if (Err_RAU !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b want=%0b", cyc, Err_RAU, m_err); end
      lw = $urandom % 8;
      lr = $urandom % 8;
      look(lw, lr);
      total++;
      if (Valid_RAU_RF !== exp_valid(lw, lr) || PhyReg_RAU_RF !== 5'(exp_phy(lw, lr)) || SWWarpID_RAU_RF !== m_sw[lw]) begin
        bad++;
        $display("FAIL rnd_lookup cyc=%0d w=%0d r=%0d valid=%0b phy=%0d sw=%0h want %0b/%0d/%0h", cyc, lw, lr, Valid_RAU_RF, PhyReg_RAU_RF, SWWarpID_RAU_RF, exp_valid(lw, lr), exp_phy(lw, lr), m_sw[lw]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_alloc();
    test_fragmentation();
    test_nreg_zero();
    test_overlap();
    test_back_to_back();
    test_errors();
    test_fill_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
